// File: rtl/rtc_pkg.sv
// Shared constants for the real-time clock: the CPU register map, the
// time-field limits and the alarm control bit positions.
package rtc_pkg;

    // Register codes decoded from addr[3:0]; addr[7:4] selects the alarm channel.
    localparam logic [3:0] REG_HOUR  = 4'h8;
    localparam logic [3:0] REG_MIN   = 4'h9;
    localparam logic [3:0] REG_SEC   = 4'hA;
    localparam logic [3:0] REG_AHOUR = 4'hC;
    localparam logic [3:0] REG_AMIN  = 4'hD;
    localparam logic [3:0] REG_ACTRL = 4'hE;

    // Largest legal values of the time fields.
    localparam logic [5:0] MAX_HOUR    = 6'd23;
    localparam logic [5:0] MAX_MIN_SEC = 6'd59;

    // Bit positions inside an alarm control write.
    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    // True when a 6-bit write value lies inside 0..max.
    function automatic logic in_range(input logic [5:0] value, input logic [5:0] max);
        return value <= max;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Generic seconds prescaler: counts 0..CLK_FREQ-1 and flags the wrap.
// tick is high during the cycle the counter sits at its last value, so the
// consumer advances its own registers on the same edge the counter wraps.
// clr restarts the count from zero and suppresses that cycle's tick.
module rtc_prescaler #(
    parameter int CLK_FREQ = 10000000
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          at_last;

    assign at_last = (count_reg == LAST);
    assign tick    = at_last & ~clr;

    // Next count: restart on wrap or on an explicit clear.
    always_comb begin
        count_next = count_reg + CW'(1);
        if (clr || at_last) begin
            count_next = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rtc_alarm_timer.sv
// Real-time clock with CPU-settable hour:minute:second and NUM_ALARMS
// hour:minute alarm channels. Each channel keeps a sticky pending flag; irq
// is the registered OR of pending flags whose channel is enabled.
module rtc_alarm_timer #(
    parameter int CLK_FREQ   = 10000000,
    parameter int NUM_ALARMS = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  w_en_n,
    input  logic [DATA_W-1:0]     t,
    input  logic [ADDR_W-1:0]     addr,
    output logic [4:0]            hour,
    output logic [5:0]            minute,
    output logic [5:0]            second,
    output logic                  sec_tick,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    output logic                  irq
);

    import rtc_pkg::*;

    // ---------------------------------------------------------------
    // CPU write detection
    // ---------------------------------------------------------------
    logic w_prev_reg;
    logic armed_reg;
    logic commit;

    // armed_reg stays low until the strobe has been seen high after reset,
    // so a low phase that straddles reset never produces a commit.
    always_ff @(posedge clock) begin
        if (rst) begin
            w_prev_reg <= 1'b1;
            armed_reg  <= 1'b0;
        end else begin
            w_prev_reg <= w_en_n;
            armed_reg  <= armed_reg | w_en_n;
        end
    end

    assign commit = armed_reg & ~w_prev_reg & w_en_n;

    // ---------------------------------------------------------------
    // Write decode
    // ---------------------------------------------------------------
    logic [3:0] reg_code;
    logic [3:0] ch_sel;
    logic [5:0] wdata;
    logic       data_ok;
    logic       wr_hour;
    logic       wr_min;
    logic       wr_sec;
    logic       unused_addr;

    assign reg_code = addr[3:0];
    assign ch_sel   = addr[7:4];
    assign wdata    = t[5:0];
    // Any set bit above t[5] makes the whole write invalid.
    assign data_ok  = ((t >> 6) == '0);

    // The channel field only means something for the alarm registers.
    assign wr_hour = commit & data_ok & (reg_code == REG_HOUR) & in_range(wdata, MAX_HOUR);
    assign wr_min  = commit & data_ok & (reg_code == REG_MIN)  & in_range(wdata, MAX_MIN_SEC);
    assign wr_sec  = commit & data_ok & (reg_code == REG_SEC)  & in_range(wdata, MAX_MIN_SEC);

    assign unused_addr = &{1'b0, addr[ADDR_W-1:8]};

    // ---------------------------------------------------------------
    // Seconds prescaler (a seconds write restarts it and eats the tick)
    // ---------------------------------------------------------------
    logic tick;

    rtc_prescaler #(
        .CLK_FREQ (CLK_FREQ)
    ) u_prescaler (
        .clock (clock),
        .rst   (rst),
        .clr   (wr_sec),
        .tick  (tick)
    );

    // ---------------------------------------------------------------
    // Time of day
    // ---------------------------------------------------------------
    logic [4:0] hour_reg;
    logic [5:0] minute_reg;
    logic [5:0] second_reg;
    logic [4:0] hour_next;
    logic [5:0] minute_next;
    logic [5:0] second_next;
    logic       sec_wrap;
    logic       min_wrap;
    logic       minute_boundary;
    logic       sec_tick_reg;

    // Tick cascade, then CPU writes override their own field. A carry out of
    // a written minute is dropped so the hour does not move under the write.
    always_comb begin
        second_next = second_reg;
        minute_next = minute_reg;
        hour_next   = hour_reg;
        sec_wrap    = tick & (second_reg == MAX_MIN_SEC);
        min_wrap    = sec_wrap & (minute_reg == MAX_MIN_SEC);

        if (tick) begin
            second_next = sec_wrap ? 6'd0 : second_reg + 6'd1;
        end
        if (sec_wrap) begin
            minute_next = min_wrap ? 6'd0 : minute_reg + 6'd1;
        end
        if (min_wrap && !wr_min) begin
            hour_next = (hour_reg == MAX_HOUR[4:0]) ? 5'd0 : hour_reg + 5'd1;
        end

        if (wr_sec) begin
            second_next = wdata;
        end
        if (wr_min) begin
            minute_next = wdata;
        end
        if (wr_hour) begin
            hour_next = wdata[4:0];
        end
    end

    // Alarms only fire on a minute boundary reached by counting, never when
    // the CPU is moving the hour or minute in the same cycle.
    assign minute_boundary = sec_wrap & ~wr_hour & ~wr_min;

    // Time registers and the registered one-cycle second pulse.
    always_ff @(posedge clock) begin
        if (rst) begin
            hour_reg     <= 5'd0;
            minute_reg   <= 6'd0;
            second_reg   <= 6'd0;
            sec_tick_reg <= 1'b0;
        end else begin
            hour_reg     <= hour_next;
            minute_reg   <= minute_next;
            second_reg   <= second_next;
            sec_tick_reg <= tick;
        end
    end

    // ---------------------------------------------------------------
    // Alarm channels
    // ---------------------------------------------------------------
    logic [NUM_ALARMS-1:0] pend_vec;
    logic [NUM_ALARMS-1:0] en_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
            logic [4:0] ahour_reg;
            logic [5:0] amin_reg;
            logic       en_reg;
            logic       pend_reg;
            logic       sel;
            logic       match;

            // Channel numbers at or above NUM_ALARMS match no channel.
            assign sel   = commit & data_ok & (ch_sel == 4'(gi));
            assign match = minute_boundary & en_reg
                         & (ahour_reg == hour_next) & (amin_reg == minute_next);

            // Alarm set-up registers and the sticky pending flag (set beats clear).
            always_ff @(posedge clock) begin
                if (rst) begin
                    ahour_reg <= 5'd0;
                    amin_reg  <= 6'd0;
                    en_reg    <= 1'b0;
                    pend_reg  <= 1'b0;
                end else begin
                    if (sel && (reg_code == REG_AHOUR) && in_range(wdata, MAX_HOUR)) begin
                        ahour_reg <= wdata[4:0];
                    end
                    if (sel && (reg_code == REG_AMIN) && in_range(wdata, MAX_MIN_SEC)) begin
                        amin_reg <= wdata;
                    end
                    if (sel && (reg_code == REG_ACTRL)) begin
                        en_reg <= wdata[CTRL_EN];
                    end
                    if (match) begin
                        pend_reg <= 1'b1;
                    end else if (sel && (reg_code == REG_ACTRL) && wdata[CTRL_CLR]) begin
                        pend_reg <= 1'b0;
                    end
                end
            end

            assign pend_vec[gi] = pend_reg;
            assign en_vec[gi]   = en_reg;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Interrupt
    // ---------------------------------------------------------------
    logic irq_reg;

    // irq trails the enabled pending flags by one cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(pend_vec & en_vec);
        end
    end

    assign hour          = hour_reg;
    assign minute        = minute_reg;
    assign second        = second_reg;
    assign sec_tick      = sec_tick_reg;
    assign alarm_pending = pend_vec;
    assign irq           = irq_reg;

endmodule
